// File: rtl/grid_cursor_rpt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : grid_cursor_rpt                                              |
// | Description : 2-D keypad-grid cursor with auto-repeat, optional wrap and   |
// |               a per-cell forbidden mask. Outputs cursor x/y, linear index  |
// |               and one-cycle moved/bumped pulses.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module grid_cursor_rpt #(
  parameter  int COLS         = 6,
  parameter  int ROWS         = 4,
  parameter  int REPEAT_DELAY = 25_000_000,
  parameter  int REPEAT_RATE  = 6_250_000,
  localparam int XW           = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int YW           = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int VW           = $clog2(COLS * ROWS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_dir_up,
  input  logic                   i_dir_down,
  input  logic                   i_dir_left,
  input  logic                   i_dir_right,
  input  logic                   i_wrap_en,
  input  logic                   i_home,
  input  logic [COLS*ROWS-1:0]   i_blocked,
  output logic [XW-1:0]          o_pos_x,
  output logic [YW-1:0]          o_pos_y,
  output logic [VW-1:0]          o_val,
  output logic                   o_moved,
  output logic                   o_bumped
);

  // One counter serves both the initial delay and the repeat period.
  localparam int              c_CNT_MAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int              c_CW        = $clog2(c_CNT_MAX);
  localparam logic [c_CW-1:0] c_DLY_LAST  = c_CW'(REPEAT_DELAY - 1);
  localparam logic [c_CW-1:0] c_RATE_LAST = c_CW'(REPEAT_RATE - 1);
  localparam logic [XW-1:0]   c_X_LAST    = XW'(COLS - 1);
  localparam logic [YW-1:0]   c_Y_LAST    = YW'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  state_t          r_state, w_state_nxt;
  dir_t            r_dir, w_dir_nxt;
  dir_t            w_sel, w_step_dir;
  logic [c_CW-1:0] r_cnt, w_cnt_nxt;
  logic            w_held, w_step;

  logic [XW-1:0]   r_x, w_tx;
  logic [YW-1:0]   r_y, w_ty;
  logic            w_oob, w_reject;
  logic [VW-1:0]   w_tidx;
  logic            r_moved, r_bumped;

  // Highest-priority asserted button: up, down, left, right.
  always_comb begin
    w_sel = DIR_NONE;
    if (i_dir_up)         w_sel = DIR_UP;
    else if (i_dir_down)  w_sel = DIR_DOWN;
    else if (i_dir_left)  w_sel = DIR_LEFT;
    else if (i_dir_right) w_sel = DIR_RIGHT;
  end

  // Is the button belonging to the latched direction still pressed?
  always_comb begin
    w_held = 1'b0;
    case (r_dir)
      DIR_UP:    w_held = i_dir_up;
      DIR_DOWN:  w_held = i_dir_down;
      DIR_LEFT:  w_held = i_dir_left;
      DIR_RIGHT: w_held = i_dir_right;
      default:   w_held = 1'b0;
    endcase
  end

  // Repeat FSM next state, counter and step request; home overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_step      = 1'b0;
    w_step_dir  = r_dir;
    case (r_state)
      ST_IDLE: begin
        if (w_sel != DIR_NONE) begin
          w_dir_nxt   = w_sel;
          w_step_dir  = w_sel;
          w_step      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (!w_held) begin
          w_dir_nxt   = DIR_NONE;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == c_DLY_LAST) begin
          w_step      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_REPEAT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!w_held) begin
          w_dir_nxt   = DIR_NONE;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == c_RATE_LAST) begin
          w_step    = 1'b1;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_dir_nxt   = DIR_NONE;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (i_home) begin
      w_step      = 1'b0;
      w_dir_nxt   = DIR_NONE;
      w_cnt_nxt   = '0;
      w_state_nxt = ST_IDLE;
    end
  end

  // FSM, counter and latched-direction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dir   <= DIR_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  // Target cell of the step; out-of-grid targets are pre-wrapped and flagged.
  always_comb begin
    w_tx  = r_x;
    w_ty  = r_y;
    w_oob = 1'b0;
    case (w_step_dir)
      DIR_UP: begin
        if (r_y == '0) begin
          w_oob = 1'b1;
          w_ty  = c_Y_LAST;
        end else begin
          w_ty = r_y - 1'b1;
        end
      end
      DIR_DOWN: begin
        if (r_y == c_Y_LAST) begin
          w_oob = 1'b1;
          w_ty  = '0;
        end else begin
          w_ty = r_y + 1'b1;
        end
      end
      DIR_LEFT: begin
        if (r_x == '0) begin
          w_oob = 1'b1;
          w_tx  = c_X_LAST;
        end else begin
          w_tx = r_x - 1'b1;
        end
      end
      DIR_RIGHT: begin
        if (r_x == c_X_LAST) begin
          w_oob = 1'b1;
          w_tx  = '0;
        end else begin
          w_tx = r_x + 1'b1;
        end
      end
      default: begin
        w_tx  = r_x;
        w_ty  = r_y;
        w_oob = 1'b0;
      end
    endcase
  end

  // Only the adjacent target cell is examined, so a blocked cell is never skipped.
  assign w_tidx   = VW'(int'(w_ty) * COLS + int'(w_tx));
  assign w_reject = (w_oob & ~i_wrap_en) | i_blocked[w_tidx];

  // Position registers with moved/bumped pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_moved  <= 1'b0;
      r_bumped <= 1'b0;
    end else begin
      r_moved  <= 1'b0;
      r_bumped <= 1'b0;
      if (i_home) begin
        r_x     <= '0;
        r_y     <= '0;
        r_moved <= (r_x != '0) || (r_y != '0);
      end else if (w_step) begin
        if (w_reject) begin
          r_bumped <= 1'b1;
        end else begin
          r_x     <= w_tx;
          r_y     <= w_ty;
          r_moved <= 1'b1;
        end
      end
    end
  end

  assign o_pos_x  = r_x;
  assign o_pos_y  = r_y;
  assign o_val    = VW'(int'(r_y) * COLS + int'(r_x));
  assign o_moved  = r_moved;
  assign o_bumped = r_bumped;

endmodule
`default_nettype wire

// File: tb/tb_grid_cursor_rpt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_grid_cursor_rpt                                           |
// | Description : Self-checking bench for grid_cursor_rpt (6x4, delay 8,       |
// |               rate 4): vector table, directed multi-cycle sequences and a  |
// |               randomized run against a behavioural cursor model.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_grid_cursor_rpt;

  localparam int C_COLS = 6;
  localparam int C_ROWS = 4;
  localparam int C_DLY  = 8;
  localparam int C_RATE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        up, down, left, right, wrap, home;
  logic [23:0] blk;
  logic [2:0]  px;
  logic [1:0]  py;
  logic [4:0]  pv;
  logic        moved, bumped;

  int checks = 0;
  int errors = 0;

  grid_cursor_rpt #(
    .COLS(C_COLS), .ROWS(C_ROWS), .REPEAT_DELAY(C_DLY), .REPEAT_RATE(C_RATE)
  ) dut (
    .clk(clk), .rst(rst),
    .i_dir_up(up), .i_dir_down(down), .i_dir_left(left), .i_dir_right(right),
    .i_wrap_en(wrap), .i_home(home), .i_blocked(blk),
    .o_pos_x(px), .o_pos_y(py), .o_val(pv), .o_moved(moved), .o_bumped(bumped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  dirs;   // {up, down, left, right}
    bit          wr;
    bit          hm;
    logic [23:0] bl;
    int          ex, ey;
    bit          em, eb;
  } vec_t;

  vec_t vq[$];

  // Behavioural model state
  int mx, my, mactive, mstart, cyc;
  bit mm, mb;

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_all(string tag, int ex, int ey, bit em, bit eb);
    chk({tag, " x"}, int'(px), ex);
    chk({tag, " y"}, int'(py), ey);
    chk({tag, " val"}, int'(pv), ey * C_COLS + ex);
    chk({tag, " moved"}, int'(moved), int'(em));
    chk({tag, " bumped"}, int'(bumped), int'(eb));
  endtask

  task automatic addv(logic [3:0] d, bit w, bit h, logic [23:0] b, int ex, int ey, bit em, bit eb);
    vec_t v;
    v.dirs = d; v.wr = w; v.hm = h; v.bl = b;
    v.ex = ex; v.ey = ey; v.em = em; v.eb = eb;
    vq.push_back(v);
  endtask

  task automatic set_dirs(logic [3:0] d);
    {up, down, left, right} = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(logic [3:0] d);
    set_dirs(d);
    tick();
    set_dirs(4'b0000);
    tick();
  endtask

  // One accepted/rejected step from the model's grid rules.
  task automatic model_step(int dir);
    int tx, ty;
    bit rej;
    tx = mx; ty = my; rej = 1'b0;
    case (dir)
      1: ty = my - 1;
      2: ty = my + 1;
      3: tx = mx - 1;
      default: tx = mx + 1;
    endcase
    if (tx < 0 || tx >= C_COLS || ty < 0 || ty >= C_ROWS) begin
      if (wrap) begin
        tx = (tx + C_COLS) % C_COLS;
        ty = (ty + C_ROWS) % C_ROWS;
      end else begin
        rej = 1'b1;
      end
    end
    if (!rej && blk[ty * C_COLS + tx]) rej = 1'b1;
    if (rej) mb = 1'b1;
    else begin
      mx = tx; my = ty; mm = 1'b1;
    end
  endtask

  // Model for one clock edge: steps happen at press time, after the delay,
  // then every rate period while the pressed button stays held.
  task automatic model_edge();
    int  sel, e;
    bit  held, stp;
    mm = 1'b0; mb = 1'b0; stp = 1'b0;
    sel  = up ? 1 : down ? 2 : left ? 3 : right ? 4 : 0;
    held = (mactive == 1 && up) || (mactive == 2 && down) ||
           (mactive == 3 && left) || (mactive == 4 && right);
    if (home) begin
      mm = (mx != 0 || my != 0);
      mx = 0; my = 0; mactive = 0;
    end else if (mactive == 0) begin
      if (sel != 0) begin
        mactive = sel; mstart = cyc; stp = 1'b1;
      end
    end else if (!held) begin
      mactive = 0;
    end else begin
      e   = cyc - mstart;
      stp = (e == C_DLY) || (e > C_DLY && ((e - C_DLY) % C_RATE) == 0);
    end
    if (stp) model_step(mactive);
    cyc++;
  endtask

  initial begin
    int r;
    rst = 1'b1; set_dirs(4'b0000); wrap = 1'b0; home = 1'b0; blk = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 1'b0, 1'b0);
    rst = 1'b0;

    // ---- vector table ----
    addv(4'b0001, 0, 0, 24'h0,  1, 0, 1, 0);
    addv(4'b0000, 0, 0, 24'h0,  1, 0, 0, 0);
    addv(4'b0001, 0, 0, 24'h0,  2, 0, 1, 0);
    addv(4'b0000, 0, 0, 24'h0,  2, 0, 0, 0);
    addv(4'b0001, 0, 0, 24'h0,  3, 0, 1, 0);
    addv(4'b0000, 0, 0, 24'h0,  3, 0, 0, 0);
    addv(4'b0000, 0, 1, 24'h0,  0, 0, 1, 0);
    addv(4'b0100, 0, 0, 24'h0,  0, 1, 1, 0);
    addv(4'b0000, 0, 0, 24'h0,  0, 1, 0, 0);
    addv(4'b0001, 0, 0, 24'h80, 0, 1, 0, 1);
    addv(4'b0000, 0, 0, 24'h80, 0, 1, 0, 0);
    addv(4'b0001, 0, 0, 24'h0,  1, 1, 1, 0);
    addv(4'b0000, 0, 0, 24'h0,  1, 1, 0, 0);
    addv(4'b0000, 0, 1, 24'h0,  0, 0, 1, 0);
    addv(4'b1000, 1, 0, 24'h0,  0, 3, 1, 0);
    addv(4'b0000, 1, 0, 24'h0,  0, 3, 0, 0);
    addv(4'b0010, 1, 0, 24'h0,  5, 3, 1, 0);
    addv(4'b0000, 1, 0, 24'h0,  5, 3, 0, 0);
    addv(4'b0001, 1, 0, 24'h0,  0, 3, 1, 0);
    addv(4'b0000, 1, 0, 24'h0,  0, 3, 0, 0);
    addv(4'b0010, 0, 0, 24'h0,  0, 3, 0, 1);
    addv(4'b0000, 0, 0, 24'h0,  0, 3, 0, 0);
    addv(4'b0100, 1, 0, 24'h0,  0, 0, 1, 0);
    addv(4'b0000, 1, 0, 24'h0,  0, 0, 0, 0);
    addv(4'b0100, 0, 0, 24'h0,  0, 1, 1, 0);
    addv(4'b0000, 0, 0, 24'h0,  0, 1, 0, 0);
    addv(4'b0000, 0, 1, 24'h0,  0, 0, 1, 0);
    addv(4'b0000, 0, 1, 24'h0,  0, 0, 0, 0);
    addv(4'b0001, 0, 1, 24'h0,  0, 0, 0, 0);
    addv(4'b0000, 0, 0, 24'h0,  0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      set_dirs(vq[i].dirs); wrap = vq[i].wr; home = vq[i].hm; blk = vq[i].bl;
      tick();
      chk_all($sformatf("vec%0d", i), vq[i].ex, vq[i].ey, vq[i].em, vq[i].eb);
    end
    set_dirs(4'b0000); wrap = 1'b0; home = 1'b0; blk = '0;

    // ---- held down with no wrap: steps at 0, 8, 12, 16; the last one bumps ----
    down = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_all($sformatf("hold_down t%0d", i), 0, (i >= 12) ? 3 : (i >= 8) ? 2 : 1,
              (i == 0 || i == 8 || i == 12), (i == 16));
    end
    down = 1'b0;
    tick();

    // ---- simultaneous up+left, then left as a fresh press ----
    pulse(4'b1000);
    pulse(4'b0001);
    pulse(4'b0001);
    chk_all("prio setup", 2, 2, 1'b0, 1'b0);
    set_dirs(4'b1010);
    tick();
    chk_all("prio up", 2, 1, 1'b1, 1'b0);
    set_dirs(4'b0010);
    tick();
    chk_all("prio release", 2, 1, 1'b0, 1'b0);
    tick();
    chk_all("prio left", 1, 1, 1'b1, 1'b0);
    set_dirs(4'b0000);
    tick();

    // ---- asynchronous reset during a held repeat ----
    home = 1'b1;
    tick();
    home = 1'b0;
    right = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk_all("rst pre", 2, 0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_all("rst async", 0, 0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_all("rst repress", 1, 0, 1'b1, 1'b0);
    right = 1'b0;
    tick();

    // ---- randomized run against the behavioural model ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mx = 0; my = 0; mactive = 0; mstart = 0; cyc = 0; mm = 1'b0; mb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        r = int'($urandom_range(0, 9));
        if (r < 4)      set_dirs(4'b0000);
        else if (r < 8) set_dirs(4'(1 << (r - 4)));
        else            set_dirs(4'($urandom));
      end
      if ($urandom_range(0, 15) == 0) wrap = ~wrap;
      if ((i % 64) == 0) blk = 24'($urandom & $urandom);
      home = ($urandom_range(0, 79) == 0);
      @(posedge clk);
      model_edge();
      #1;
      chk_all("rand", mx, my, mm, mb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
